// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - load/store size encodings (func3 values)
//   - responder FSM state encoding
//   - dmem_misaligned(): alignment rule used when DMEM_MISALIGN_CHECK_EN is defined
package dmem_pkg;

    localparam logic [2:0] DMEM_SZ_B  = 3'd0;
    localparam logic [2:0] DMEM_SZ_H  = 3'd1;
    localparam logic [2:0] DMEM_SZ_W  = 3'd2;
    localparam logic [2:0] DMEM_SZ_BU = 3'd4;
    localparam logic [2:0] DMEM_SZ_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_e;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    function automatic logic dmem_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            DMEM_SZ_H, DMEM_SZ_HU: mis = addr_lo[0];
            DMEM_SZ_W:             mis = (addr_lo != 2'b00);
            default:               mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational lane formatting for the data-memory responder.
//   size       in  3   func3 size code (stores use size[1:0])
//   addr_lo    in  2   byte offset within the word
//   st_data    in  32  right-aligned store data
//   ld_word    in  32  raw word returned by memory
//   wmask      out 4   byte enables for a store
//   wdata_rep  out 32  store data replicated across lanes
//   ld_data    out 32  extracted and sign/zero-extended load data
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Half select only looks at addr_lo[1]; an odd halfword address
    // therefore reads the aligned halfword it falls in.
    assign ld_byte = ld_word[{addr_lo, 3'b000} +: 8];
    assign ld_half = ld_word[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        wmask     = 4'b1111;
        wdata_rep = st_data;
        case (size[1:0])
            2'd0: begin
                wmask     = 4'b0001 << addr_lo;
                wdata_rep = {4{st_data[7:0]}};
            end
            2'd1: begin
                wmask     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{st_data[15:0]}};
            end
            default: begin
                wmask     = 4'b1111;
                wdata_rep = st_data;
            end
        endcase
    end

    always_comb begin
        ld_data = ld_word;
        case (size)
            DMEM_SZ_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            DMEM_SZ_H:  ld_data = {{16{ld_half[15]}}, ld_half};
            DMEM_SZ_BU: ld_data = {24'd0, ld_byte};
            DMEM_SZ_HU: ld_data = {16'd0, ld_half};
            default:    ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the pipeline's data-memory requests.
// Captures one load/store, runs the memory ready/valid handshake, stalls the
// pipeline until completion and returns registered, extended load data.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (misaligned H/W accesses skip
// memory and complete with cpu_misalign=1).
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req_*                  request from the core, held while cpu_stall=1
//   cpu_st_size / cpu_ld_size  func3 size codes
//   cpu_stall                  hold pipeline
//   cpu_resp_valid/_data       completion pulse and registered load data
//   cpu_misalign               misaligned-access pulse (0 when feature disabled)
//   mem_req_*                  request channel to the data memory
//   mem_resp_valid/_data       read return from the data memory
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    input  logic [1:0]            cpu_st_size,
    input  logic [2:0]            cpu_ld_size,
    output logic                  cpu_stall,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_resp_data,
    output logic                  cpu_misalign,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    dmem_state_e           state, state_nxt;
    logic                  req_we;
    logic [2:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic [2:0]            in_size;
    logic                  in_misalign;
    logic [3:0]            fmt_wmask;
    logic [DATA_WIDTH-1:0] fmt_wdata;
    logic [DATA_WIDTH-1:0] fmt_ld;

    // One size register serves both directions; store codes never exceed 3.
    assign in_size = cpu_req_we ? {1'b0, cpu_st_size} : cpu_ld_size;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic mis_q;
    assign in_misalign  = dmem_misaligned(in_size, cpu_req_addr[1:0]);
    assign cpu_misalign = cpu_resp_valid & mis_q;
`else
    assign in_misalign  = 1'b0;
    assign cpu_misalign = 1'b0;
`endif

    dmem_lane_fmt u_fmt (
        .size      (req_size),
        .addr_lo   (req_addr[1:0]),
        .st_data   (req_wdata),
        .ld_word   (mem_resp_data),
        .wmask     (fmt_wmask),
        .wdata_rep (fmt_wdata),
        .ld_data   (fmt_ld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            req_we        <= 1'b0;
            req_size      <= 3'd0;
            req_addr      <= '0;
            req_wdata     <= '0;
            cpu_resp_data <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
            mis_q         <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && cpu_req_valid) begin
                req_we    <= cpu_req_we;
                req_size  <= in_size;
                req_addr  <= cpu_req_addr;
                req_wdata <= cpu_req_wdata;
`ifdef DMEM_MISALIGN_CHECK_EN
                mis_q     <= in_misalign;
`endif
            end
            if (state == ST_WAIT && mem_resp_valid)
                cpu_resp_data <= fmt_ld;
        end
    end

    always_comb begin
        state_nxt      = state;
        cpu_stall      = 1'b0;
        cpu_resp_valid = 1'b0;
        mem_req_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_stall = cpu_req_valid;
                if (cpu_req_valid)
                    state_nxt = in_misalign ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                cpu_stall     = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    state_nxt = req_we ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                cpu_stall = 1'b1;
                if (mem_resp_valid)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // cpu_req_valid here is still the completed request; ignore it.
                cpu_resp_valid = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request channel is driven only in REQ so it reads as all-zero otherwise.
    assign mem_req_rw    = mem_req_valid & req_we;
    assign mem_req_addr  = mem_req_valid ? {req_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_req_wdata = mem_req_rw ? fmt_wdata : '0;
    assign mem_req_wmask = mem_req_rw ? fmt_wmask : 4'b0000;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req_valid, cpu_req_we;
    logic [31:0] cpu_req_addr, cpu_req_wdata;
    logic [1:0]  cpu_st_size;
    logic [2:0]  cpu_ld_size;
    logic        cpu_stall, cpu_resp_valid, cpu_misalign;
    logic [31:0] cpu_resp_data;
    logic        mem_req_valid, mem_req_ready, mem_req_rw;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_st_size(cpu_st_size), .cpu_ld_size(cpu_ld_size),
        .cpu_stall(cpu_stall), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_data(cpu_resp_data), .cpu_misalign(cpu_misalign),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] bus_mem [16];   // memory behind the bus, written through DUT masks
    logic [7:0]  ref_mem [64];   // byte-level reference memory
    logic [31:0] last_resp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int eff_addr(input logic [2:0] sz, input logic [31:0] a);
        case (sz)
            3'd0, 3'd4: return int'(a[5:0]);
            3'd1, 3'd5: return int'(a[5:0]) & ~1;
            default:    return int'(a[5:0]) & ~3;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] a);
        logic [31:0] v;
        int base;
        v = 32'd0;
        base = eff_addr(sz, a);
        for (int i = 0; i < nbytes(sz); i++)
            v = v | (32'(ref_mem[(base + i) & 63]) << (8 * i));
        if (sz == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (sz == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int base;
        base = eff_addr(sz, a);
        for (int i = 0; i < nbytes(sz); i++)
            ref_mem[(base + i) & 63] = wd[8*i +: 8];
    endtask

    function automatic logic [3:0] exp_mask(input logic [2:0] sz, input logic [31:0] a);
        case (sz)
            3'd0:    return 4'(1 << a[1:0]);
            3'd1:    return 4'(3 << (a[1] ? 2 : 0));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] sz, input logic [31:0] wd);
        case (sz)
            3'd0:    return {4{wd[7:0]}};
            3'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic exp_mis(input logic [2:0] sz, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((sz == 3'd1 || sz == 3'd5) && a[0]) return 1'b1;
        if (sz == 3'd2 && a[1:0] != 2'b00)      return 1'b1;
`endif
        return 1'b0;
    endfunction

    // ---------------- one access, core side + memory side ----------------
    task automatic do_access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd, input int rdy_dly, input int rsp_dly,
                             output int lat, output int stalls, output logic [31:0] rdata,
                             output logic [3:0] mask_seen, output logic [31:0] wdata_seen,
                             output logic [31:0] maddr_seen, output logic req_seen,
                             output logic mis_seen, output logic unstable);
        int c, req_cycles, rcnt, idx;
        logic done, pend, hs;
        cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wd;
        cpu_st_size = sz[1:0]; cpu_ld_size = sz;
        c = 0; req_cycles = 0; rcnt = 0; idx = 0; done = 0; pend = 0;
        lat = -1; stalls = 0; mask_seen = 0; wdata_seen = 0; maddr_seen = 0;
        req_seen = 0; mis_seen = 0; unstable = 0;
        while (!done && c < 60) begin
            c++;
            #1;
            if (cpu_stall) stalls++;
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            hs = 1'b0;
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (!req_seen) begin
                    mask_seen = mem_req_wmask; wdata_seen = mem_req_wdata; maddr_seen = mem_req_addr;
                end else if (mask_seen !== mem_req_wmask || wdata_seen !== mem_req_wdata ||
                             maddr_seen !== mem_req_addr)
                    unstable = 1'b1;
                req_seen = 1'b1;
                idx = int'(mem_req_addr[5:2]);
                if (req_cycles >= rdy_dly) begin
                    mem_req_ready = 1'b1;
                    hs = 1'b1;
                    if (mem_req_rw) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_req_wmask[i]) bus_mem[idx][8*i +: 8] = mem_req_wdata[8*i +: 8];
                    end else begin
                        pend = 1'b1; rcnt = 0;
                    end
                end
                req_cycles++;
            end
            if (pend && !hs) begin
                if (rcnt >= rsp_dly) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = bus_mem[idx];
                    pend = 1'b0;
                end else rcnt++;
            end
            if (cpu_resp_valid) begin
                done = 1'b1; lat = c; mis_seen = cpu_misalign;
            end
            @(negedge clk);
        end
        cpu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        rdata = cpu_resp_data;
        chk("completion", 32'(done), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  sz;
        logic [31:0] addr, wdata, mword;
        int          rdy, rsp;
        logic [3:0]  emask;
        logic [31:0] ewdata, eresp;
        int          elat;
    } vec_t;

    vec_t        vt [9];
    int          lat, stalls;
    logic [31:0] rdata, wseen, aseen;
    logic [3:0]  mseen;
    logic        rseen, mseen_f, unst;

    initial begin
        vt[0] = '{1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0, 4'b1000, 32'hABAB_ABAB, 32'h0, 3};
        vt[1] = '{1'b0, 3'd1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0, 4'h0, 32'h0, 32'hFFFF_8001, 4};
        vt[2] = '{1'b0, 3'd4, 32'h0000_2001, 32'h0, 32'h0000_F000, 5, 0, 4'h0, 32'h0, 32'h0000_00F0, 9};
        vt[3] = '{1'b1, 3'd1, 32'h0000_2006, 32'h1234_5678, 32'h0, 0, 0, 4'b1100, 32'h5678_5678, 32'h0, 3};
        vt[4] = '{1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4};
        vt[5] = '{1'b0, 3'd0, 32'h0000_0013, 32'h0, 32'h80FF_FFFF, 0, 0, 4'h0, 32'h0, 32'hFFFF_FF80, 4};
        vt[6] = '{1'b0, 3'd5, 32'h0000_0002, 32'h0, 32'h8001_1234, 0, 2, 4'h0, 32'h0, 32'h0000_8001, 6};
        vt[7] = '{1'b0, 3'd2, 32'h0000_0004, 32'h0, 32'h1234_5678, 2, 3, 4'h0, 32'h0, 32'h1234_5678, 9};
        vt[8] = '{1'b0, 3'd3, 32'h0000_0001, 32'h0, 32'hCAFE_BABE, 0, 0, 4'h0, 32'h0, 32'hCAFE_BABE, 4};

        reset = 1'b1; cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = 0; cpu_req_wdata = 0;
        cpu_st_size = 0; cpu_ld_size = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        for (int i = 0; i < 16; i++) bus_mem[i] = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {26'd0, cpu_stall, cpu_resp_valid, cpu_misalign, mem_req_valid, mem_req_rw, 1'b0}, 32'd0);
        chk("reset_resp_data", cpu_resp_data, 32'd0);
        chk("reset_mem_bus", mem_req_addr | mem_req_wdata | {28'd0, mem_req_wmask}, 32'd0);
        // stale response right after reset must be ignored
        reset = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_AAAA;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("stale_resp_valid", {31'd0, cpu_resp_valid | cpu_stall | mem_req_valid}, 32'd0);
        chk("stale_resp_data", cpu_resp_data, 32'd0);
        last_resp = 32'd0;

        // ---------------- directed table ----------------
        for (int v = 0; v < 9; v++) begin
            if (!vt[v].we) bus_mem[vt[v].addr[5:2]] = vt[v].mword;
            do_access(vt[v].we, vt[v].sz, vt[v].addr, vt[v].wdata, vt[v].rdy, vt[v].rsp,
                      lat, stalls, rdata, mseen, wseen, aseen, rseen, mseen_f, unst);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vt[v].elat));
            chk($sformatf("vec%0d_stalls", v), 32'(stalls), 32'(vt[v].elat - 1));
            chk($sformatf("vec%0d_addr", v), aseen, {vt[v].addr[31:2], 2'b00});
            chk($sformatf("vec%0d_flags", v), {30'd0, mseen_f, unst}, 32'd0);
            if (vt[v].we) begin
                chk($sformatf("vec%0d_wmask", v), {28'd0, mseen}, {28'd0, vt[v].emask});
                chk($sformatf("vec%0d_wdata", v), wseen, vt[v].ewdata);
                chk($sformatf("vec%0d_hold", v), rdata, last_resp);
            end else begin
                chk($sformatf("vec%0d_rdata", v), rdata, vt[v].eresp);
                last_resp = vt[v].eresp;
            end
        end

        // ---------------- reset while waiting for a load ----------------
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h8; cpu_ld_size = 3'd2;
        mem_req_ready = 1'b1;
        @(negedge clk);             // REQ, handshake at next edge
        @(negedge clk);             // WAIT
        mem_req_ready = 1'b0;
        chk("wait_stall", {31'd0, cpu_stall & ~mem_req_valid}, 32'd1);
        reset = 1'b1; cpu_req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
            @(negedge clk);
            chk("rst_wait_ctl", {29'd0, cpu_resp_valid, mem_req_valid, cpu_stall}, 32'd0);
            chk("rst_wait_data", cpu_resp_data, 32'd0);
        end
        mem_resp_valid = 1'b0;
        last_resp = 32'd0;

`ifdef DMEM_MISALIGN_CHECK_EN
        do_access(1'b0, 3'd2, 32'h0000_3002, 32'h0, 0, 0, lat, stalls, rdata, mseen, wseen, aseen, rseen, mseen_f, unst);
        chk("mis_latency", 32'(lat), 32'd2);
        chk("mis_flags", {30'd0, rseen, mseen_f}, 32'd1);
        chk("mis_hold", rdata, last_resp);
`endif

        // ---------------- randomized against the byte model ----------------
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
        for (int w = 0; w < 16; w++)
            bus_mem[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
        for (int n = 0; n < 150; n++) begin
            logic        we, mis;
            logic [2:0]  sz;
            logic [31:0] a, wd, e;
            int          rd, rs, el;
            logic [2:0]  ldc [8];
            ldc = '{3'd0, 3'd1, 3'd2, 3'd4, 5'd5, 3'd3, 3'd6, 3'd7};
            we = 1'($urandom_range(0, 1));
            a  = 32'h4000_0000 | 32'($urandom_range(0, 63));
            wd = $urandom;
            sz = we ? 3'($urandom_range(0, 2)) : ldc[$urandom_range(0, 7)];
            rd = $urandom_range(0, 3);
            rs = $urandom_range(0, 3);
            mis = exp_mis(sz, a);
            do_access(we, sz, a, wd, rd, rs, lat, stalls, rdata, mseen, wseen, aseen, rseen, mseen_f, unst);
            if (mis) begin
                chk("rnd_mis_latency", 32'(lat), 32'd2);
                chk("rnd_mis_flags", {30'd0, rseen, mseen_f}, 32'd1);
                chk("rnd_mis_hold", rdata, last_resp);
            end else begin
                el = we ? 3 + rd : 4 + rd + rs;
                chk("rnd_latency", 32'(lat), 32'(el));
                chk("rnd_stalls", 32'(stalls), 32'(el - 1));
                chk("rnd_flags", {30'd0, mseen_f, unst}, 32'd0);
                chk("rnd_addr", aseen, a & 32'hFFFF_FFFC);
                if (we) begin
                    chk("rnd_wmask", {28'd0, mseen}, {28'd0, exp_mask(sz, a)});
                    chk("rnd_wdata", wseen, exp_wdata(sz, wd));
                    chk("rnd_hold", rdata, last_resp);
                    ref_store(sz, a, wd);
                end else begin
                    e = ref_load(sz, a);
                    chk("rnd_rdata", rdata, e);
                    last_resp = e;
                end
            end
        end

        // ---------------- back-to-back store then load ----------------
        begin
            logic [31:0] wd;
            wd = $urandom;
            do_access(1'b1, 3'd2, 32'h4000_0010, wd, 0, 0, lat, stalls, rdata, mseen, wseen, aseen, rseen, mseen_f, unst);
            chk("b2b_store_latency", 32'(lat), 32'd3);
            do_access(1'b0, 3'd2, 32'h4000_0010, 32'h0, 0, 0, lat, stalls, rdata, mseen, wseen, aseen, rseen, mseen_f, unst);
            chk("b2b_load_latency", 32'(lat), 32'd4);
            chk("b2b_load_data", rdata, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
